// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: multi-set sequencer for an ARRAY_SIZE x ARRAY_SIZE systolic array.
// A run of N data sets is started from IDLE. Each set is one LOAD cycle followed by
// T = K + 2*ARRAY_SIZE - 1 ROLL cycles, and the last ARRAY_SIZE ROLL cycles write one
// output row each. K and N are latched at start. Stall freezes ROLL, and abort cancels the run.
// Ports:
//   clk, srstn            clock, synchronous active-low reset
//   start, abort, stall   run request, cancel, operand-not-valid freeze
//   cfg_k_depth           accumulation depth K (0 -> 1, clamped to K_MAX)
//   cfg_num_sets          data-set count N (0 -> 1, clamped to SET_MAX)
//   busy, done            run in progress / 1-cycle completion pulse
//   addr_serial_num       operand address sequence number (saturating)
//   alu_start             array shift/MAC enable
//   cycle_num             cycle index within the current set
//   matrix_index          output row being written
//   data_set              current data-set index
//   sram_write_enable     write-out SRAM strobe
module systolic_seq_ctrl #(
  parameter int ARRAY_SIZE = 8,
  parameter int K_MAX      = 32,
  parameter int SET_MAX    = 16,
  parameter int ADDR_W     = 6,
  parameter int CYC_W      = 9
) (
  input  logic                           clk,
  input  logic                           srstn,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           stall,
  input  logic [$clog2(K_MAX+1)-1:0]     cfg_k_depth,
  input  logic [$clog2(SET_MAX+1)-1:0]   cfg_num_sets,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              addr_serial_num,
  output logic                           alu_start,
  output logic [CYC_W-1:0]               cycle_num,
  output logic [$clog2(ARRAY_SIZE)-1:0]  matrix_index,
  output logic [$clog2(SET_MAX)-1:0]     data_set,
  output logic                           sram_write_enable
);
  localparam int KW  = $clog2(K_MAX+1);
  localparam int NW  = $clog2(SET_MAX+1);
  localparam int MIW = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, ROLL, DONE} state_t;
  state_t state, state_nxt;

  logic [KW-1:0]    k_lat, k_cfg;
  logic [NW-1:0]    n_lat, n_cfg;
  logic [CYC_W-1:0] t_last, win_lo;
  logic             roll_go, last_cyc, last_set, in_win, kill;

  // Normalise the config: 0 means 1, anything above the max is clamped.
  always_comb begin
    k_cfg = cfg_k_depth;
    if (cfg_k_depth == '0)               k_cfg = KW'(1);
    else if (cfg_k_depth > KW'(K_MAX))   k_cfg = KW'(K_MAX);
    n_cfg = cfg_num_sets;
    if (cfg_num_sets == '0)              n_cfg = NW'(1);
    else if (cfg_num_sets > NW'(SET_MAX)) n_cfg = NW'(SET_MAX);
  end

  assign t_last   = CYC_W'(k_lat) + CYC_W'(2*ARRAY_SIZE-2);
  assign win_lo   = CYC_W'(k_lat) + CYC_W'(ARRAY_SIZE-1);
  assign roll_go  = (state == ROLL) && !stall;
  assign last_cyc = (cycle_num == t_last);
  // The window's upper bound is implicit: ROLL never runs past t_last.
  assign in_win   = (cycle_num >= win_lo);
  assign last_set = (NW'(data_set) == n_lat - NW'(1));
  assign kill     = abort && (state != IDLE);

  always_comb begin
    state_nxt         = state;
    busy              = (state != IDLE);
    alu_start         = roll_go;
    sram_write_enable = roll_go && in_win && !abort;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = ROLL;
      ROLL:    if (roll_go && last_cyc) state_nxt = last_set ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort beats stall and the ROLL exit.
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state           <= IDLE;
      k_lat           <= '0;
      n_lat           <= '0;
      addr_serial_num <= '0;
      cycle_num       <= '0;
      matrix_index    <= '0;
      data_set        <= '0;
      done            <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (kill) begin
        addr_serial_num <= '0;
        cycle_num       <= '0;
        matrix_index    <= '0;
        data_set        <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            k_lat           <= k_cfg;
            n_lat           <= n_cfg;
            addr_serial_num <= ADDR_W'(1);
            data_set        <= '0;
          end
          LOAD: begin
            cycle_num       <= '0;
            matrix_index    <= '0;
            addr_serial_num <= ADDR_W'(2);
          end
          ROLL: if (!stall) begin
            cycle_num <= cycle_num + CYC_W'(1);
            if (addr_serial_num != '1) addr_serial_num <= addr_serial_num + ADDR_W'(1);
            if (in_win) matrix_index <= matrix_index + MIW'(1);
            if (last_cyc) begin
              if (last_set) done <= 1'b1;
              else          data_set <= data_set + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl. Expected SRAM writes (cycle, set, row, cycle_num)
// and done pulses are computed from K/N/start cycle and queued when a run is launched.
// The negedge monitors pop and compare them as the DUT produces them.
module tb_systolic_seq_ctrl;
  logic       clk, srstn, start, abort, stall;
  logic [5:0] cfg_k_depth;
  logic [4:0] cfg_num_sets;
  logic       busy, done, alu_start, sram_write_enable;
  logic [5:0] addr_serial_num;
  logic [8:0] cycle_num;
  logic [2:0] matrix_index;
  logic [3:0] data_set;

  systolic_seq_ctrl dut (
    .clk(clk), .srstn(srstn), .start(start), .abort(abort), .stall(stall),
    .cfg_k_depth(cfg_k_depth), .cfg_num_sets(cfg_num_sets),
    .busy(busy), .done(done), .addr_serial_num(addr_serial_num),
    .alu_start(alu_start), .cycle_num(cycle_num), .matrix_index(matrix_index),
    .data_set(data_set), .sram_write_enable(sram_write_enable)
  );

  typedef struct { int cyc; int ds; int mi; int cn; } wr_t;
  wr_t wq[$];
  int  dq[$];
  int  n_cmp = 0, n_err = 0, cyc = 0, n_wr = 0, n_load = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  // Start is high during cycle s. Set j's ROLL begins at s+2+j*(T+1); its writes fall on
  // ROLL cycles K+A-1 .. T-1. A stall of stall_len cycles from stall_at delays what follows.
  task automatic push_run(input int s, input int k, input int n, input int stall_at, input int stall_len);
    int t, c;
    wr_t e;
    t = k + 15;
    for (int j = 0; j < n; j++)
      for (int w = 0; w < 8; w++) begin
        c = s + 2 + j*(t+1) + k + 7 + w;
        if (stall_len > 0 && c >= stall_at) c += stall_len;
        e.cyc = c; e.ds = j; e.mi = w; e.cn = k + 7 + w;
        wq.push_back(e);
      end
    dq.push_back(s + n*(t+1) + 1 + stall_len);
  endtask

  always @(negedge clk) begin
    if (sram_write_enable) begin
      n_wr++;
      if (wq.size() == 0) chk("wr_unexpected", 32'(sram_write_enable), 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_set", 32'(data_set), e.ds);
        chk("wr_row", 32'(matrix_index), e.mi);
        chk("wr_cnum", 32'(cycle_num), e.cn);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("done_unexpected", 32'(done), 0);
      else chk("done_cyc", cyc, dq.pop_front());
    end
    if (busy && !alu_start && !done && !stall) n_load++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    srstn = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    cfg_k_depth = 6'd0; cfg_num_sets = 5'd0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addr_serial_num), 0);
    chk("rst_alu", 32'(alu_start), 0);
    chk("rst_cnum", 32'(cycle_num), 0);
    chk("rst_row", 32'(matrix_index), 0);
    chk("rst_set", 32'(data_set), 0);
    chk("rst_we", 32'(sram_write_enable), 0);
    srstn = 1'b1;
    tick();

    // K=8, N=1 single pass
    cfg_k_depth = 6'd8; cfg_num_sets = 5'd1; start = 1'b1; s = cyc;
    push_run(s, 8, 1, -1, 0);
    tick(); start = 1'b0;
    chk("s1_load_busy", 32'(busy), 1);
    chk("s1_load_alu", 32'(alu_start), 0);
    chk("s1_load_addr", 32'(addr_serial_num), 1);
    tick();
    chk("s1_roll_alu", 32'(alu_start), 1);
    chk("s1_roll_cnum", 32'(cycle_num), 0);
    chk("s1_roll_addr", 32'(addr_serial_num), 2);
    wait_to(s + 25);
    chk("s1_done", 32'(done), 1);
    tick();
    chk("s1_idle", 32'(busy), 0);
    chk("s1_q", wq.size(), 0);

    // K=4, N=3: three LOAD phases, 24 writes, one done
    cfg_k_depth = 6'd4; cfg_num_sets = 5'd3; start = 1'b1; s = cyc;
    push_run(s, 4, 3, -1, 0);
    n_load = 0; n_wr = 0;
    tick(); start = 1'b0;
    wait_to(s + 61);
    chk("s2_done", 32'(done), 1);
    tick();
    chk("s2_idle", 32'(busy), 0);
    chk("s2_final_set", 32'(data_set), 2);
    chk("s2_loads", n_load, 3);
    chk("s2_writes", n_wr, 24);

    // K=8, N=1 with a 3-cycle stall inside the write window
    cfg_k_depth = 6'd8; cfg_num_sets = 5'd1; start = 1'b1; s = cyc;
    push_run(s, 8, 1, s + 19, 3);
    n_wr = 0;
    tick(); start = 1'b0;
    wait_to(s + 19);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("s3_stall_we", 32'(sram_write_enable), 0);
      chk("s3_stall_alu", 32'(alu_start), 0);
      chk("s3_stall_row", 32'(matrix_index), 2);
      tick();
    end
    stall = 1'b0;
    wait_to(s + 28);
    chk("s3_done", 32'(done), 1);
    tick();
    chk("s3_idle", 32'(busy), 0);
    chk("s3_writes", n_wr, 8);

    // abort on the first write cycle, then a clean rerun
    start = 1'b1; s = cyc;
    tick(); start = 1'b0;
    wait_to(s + 17);
    abort = 1'b1;
    #2;
    chk("s4_abort_we", 32'(sram_write_enable), 0);
    chk("s4_abort_busy", 32'(busy), 1);
    tick(); abort = 1'b0;
    chk("s4_idle", 32'(busy), 0);
    chk("s4_cnum_clr", 32'(cycle_num), 0);
    repeat (12) tick();
    start = 1'b1; s = cyc;
    push_run(s, 8, 1, -1, 0);
    tick(); start = 1'b0;
    wait_to(s + 25);
    chk("s4_rerun_done", 32'(done), 1);
    tick();
    chk("s4_rerun_idle", 32'(busy), 0);

    // K=0 -> 1, out-of-range N -> 16; mid-run start and cfg changes ignored
    cfg_k_depth = 6'd0; cfg_num_sets = 5'd31; start = 1'b1; s = cyc;
    push_run(s, 1, 16, -1, 0);
    n_wr = 0;
    tick(); start = 1'b0;
    wait_to(s + 5);
    cfg_k_depth = 6'd5; cfg_num_sets = 5'd2; start = 1'b1;
    tick(); start = 1'b0;
    wait_to(s + 16*17 + 1);
    chk("s5_done", 32'(done), 1);
    tick();
    chk("s5_idle", 32'(busy), 0);
    chk("s5_writes", n_wr, 128);

    // reset in ROLL: everything clears, no done, no writes
    cfg_k_depth = 6'd4; cfg_num_sets = 5'd3; start = 1'b1; s = cyc;
    tick(); start = 1'b0;
    wait_to(s + 10);
    chk("s6_pre_alu", 32'(alu_start), 1);
    srstn = 1'b0;
    tick();
    chk("s6_busy", 32'(busy), 0);
    chk("s6_alu", 32'(alu_start), 0);
    chk("s6_addr", 32'(addr_serial_num), 0);
    chk("s6_cnum", 32'(cycle_num), 0);
    chk("s6_set", 32'(data_set), 0);
    chk("s6_done", 32'(done), 0);
    srstn = 1'b1;
    repeat (70) tick();

    chk("end_wq", wq.size(), 0);
    chk("end_dq", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
